seg_scan_ctrl: RTL

//  Scan controller for the multiplexed 8-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadow/active digit buffers with
// frame-aligned commit, per-slot anti-ghosting blank and leading-zero blanking.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [2:0]            wr_idx,
   input  logic [3:0]            wr_data,
   input  logic                  wr_dp,
   input  logic                  commit,
   input  logic                  lz_blank_en,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] com_n,
   output logic                  frame_tick
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] P_LAST    = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);
   localparam logic [DW-1:0] D_LAST    = DW'(NUM_DIGITS - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t                       state, state_nxt;
   logic [PW-1:0]                presc, presc_nxt;
   logic [DW-1:0]                digit, digit_nxt;
   logic                         slot_end, frame_end;
   logic [NUM_DIGITS-1:0][3:0]   shadow_val, active_val;
   logic [NUM_DIGITS-1:0]        shadow_dp, active_dp;
   logic                         commit_pending;
   logic [NUM_DIGITS-1:0]        lz_hide;
   logic                         wr_fire, idx_ok;
   logic [6:0]                   seg_nxt;
   logic                         dp_nxt;
   logic [NUM_DIGITS-1:0]        com_nxt;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b0000001;
         4'd1:    decode = 7'b1001111;
         4'd2:    decode = 7'b0010010;
         4'd3:    decode = 7'b0000110;
         4'd4:    decode = 7'b1001100;
         4'd5:    decode = 7'b0100100;
         4'd6:    decode = 7'b0100000;
         4'd7:    decode = 7'b0001111;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0000100;
         default: decode = 7'h7F;
      endcase
   endfunction

   assign wr_ready  = !reset && !commit_pending;
   assign wr_fire   = wr_valid && wr_ready;
   assign idx_ok    = {29'd0, wr_idx} < 32'(NUM_DIGITS);
   assign slot_end  = (presc == P_LAST);
   assign frame_end = slot_end && (digit == D_LAST);

   always_comb begin
      presc_nxt = slot_end ? '0 : presc + PW'(1);
      digit_nxt = digit;
      if (slot_end)
         digit_nxt = (digit == D_LAST) ? '0 : digit + DW'(1);
   end

   // A digit is suppressed when it and every more significant digit are zero.
   assign lz_hide[0] = 1'b0;
   for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
      assign lz_hide[i] = lz_blank_en && (active_val[NUM_DIGITS-1:i] == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= BLANK;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (presc_nxt < BLANK_LIM) state_nxt = BLANK;
      else                       state_nxt = DRIVE;
      com_nxt = '1;
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      if (state == DRIVE) begin
         com_nxt[digit] = 1'b0;
         seg_nxt        = lz_hide[digit] ? 7'h7F : decode(active_val[digit]);
         dp_nxt         = ~active_dp[digit];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc          <= '0;
         digit          <= '0;
         shadow_val     <= '0;
         shadow_dp      <= '0;
         active_val     <= '0;
         active_dp      <= '0;
         commit_pending <= 1'b0;
         seg_n          <= 7'h7F;
         dp_n           <= 1'b1;
         com_n          <= '1;
         frame_tick     <= 1'b0;
      end else begin
         presc      <= presc_nxt;
         digit      <= digit_nxt;
         seg_n      <= seg_nxt;
         dp_n       <= dp_nxt;
         com_n      <= com_nxt;
         // Look ahead so the pulse lines up with the boundary cycle itself.
         frame_tick <= (presc_nxt == P_LAST) && (digit_nxt == D_LAST);
         if (wr_fire && idx_ok) begin
            shadow_val[wr_idx[DW-1:0]] <= wr_data;
            shadow_dp[wr_idx[DW-1:0]]  <= wr_dp;
         end
         if (frame_end && commit_pending) begin
            active_val     <= shadow_val;
            active_dp      <= shadow_dp;
            commit_pending <= 1'b0;
         end else if (commit && !commit_pending) begin
            commit_pending <= 1'b1;
         end
      end
   end

endmodule
